// File: rtl/osnt_bram_dp_if.sv
// Port bundle for osnt_bram_dp: clear control, port A (read/write) and port B (read-only).
// The master side drives requests; the slave side is the memory.
interface osnt_bram_dp_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 736
);
  logic                      clr_start;
  logic                      clr_busy;
  logic                      a_en;
  logic [DATA_WIDTH/8-1:0]   a_we;
  logic [ADDR_WIDTH-1:0]     a_addr;
  logic [DATA_WIDTH-1:0]     a_wrdata;
  logic [DATA_WIDTH-1:0]     a_rddata;
  logic                      a_rdvalid;
  logic                      b_en;
  logic [ADDR_WIDTH-1:0]     b_addr;
  logic [DATA_WIDTH-1:0]     b_rddata;
  logic                      b_rdvalid;

  modport master (
    output clr_start, a_en, a_we, a_addr, a_wrdata, b_en, b_addr,
    input  clr_busy, a_rddata, a_rdvalid, b_rddata, b_rdvalid
  );

  modport slave (
    input  clr_start, a_en, a_we, a_addr, a_wrdata, b_en, b_addr,
    output clr_busy, a_rddata, a_rdvalid, b_rddata, b_rdvalid
  );
endinterface

// File: rtl/osnt_bram_dp.sv
// Single-clock packet-word BRAM: port A read/write with byte enables, port B read-only,
// read-first on both ports, 1- or 2-cycle registered read latency, sequential zero-clear.
module osnt_bram_dp #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 736,
  parameter int READ_LATENCY = 1
) (
  input  logic          bram_clk,
  input  logic          bram_rstn,
  osnt_bram_dp_if.slave bram
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] cnt_nxt_s;
  logic                  clr_busy_r;
  logic                  a_acc_s;
  logic                  b_acc_s;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] a_s1_data_r;
  logic [DATA_WIDTH-1:0] b_s1_data_r;
  logic                  a_s1_vld_r;
  logic                  b_s1_vld_r;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NBYTES-1:0]     byte_we
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NBYTES; i++) begin
      res[8*i +: 8] = byte_we[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("osnt_bram_dp: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  // Accesses are only honoured while the clear engine is idle; otherwise dropped.
  assign a_acc_s = bram.a_en & (state_r == ST_IDLE);
  assign b_acc_s = bram.b_en & (state_r == ST_IDLE);

  // Clear-engine next state: walk every address once, then return to idle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bram.clr_start) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cnt_nxt_s = cnt_r + ADDR_WIDTH'(1);
        if (cnt_r == {ADDR_WIDTH{1'b1}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Clear-engine state, counter and busy flag.
  always_ff @(posedge bram_clk or negedge bram_rstn) begin
    if (!bram_rstn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      clr_busy_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      clr_busy_r <= (state_nxt_s == ST_CLEAR);
    end
  end

  // Storage array; contents survive reset so that only the clear engine zeroes it.
  always_ff @(posedge bram_clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[cnt_r] <= '0;
    end else if (a_acc_s) begin
      mem_r[bram.a_addr] <= merge_bytes(mem_r[bram.a_addr], bram.a_wrdata, bram.a_we);
    end
  end

  // First read register: samples pre-write content, giving read-first behaviour.
  always_ff @(posedge bram_clk or negedge bram_rstn) begin
    if (!bram_rstn) begin
      a_s1_data_r <= '0;
      b_s1_data_r <= '0;
      a_s1_vld_r  <= 1'b0;
      b_s1_vld_r  <= 1'b0;
    end else begin
      a_s1_vld_r <= a_acc_s;
      b_s1_vld_r <= b_acc_s;
      if (a_acc_s) begin
        a_s1_data_r <= mem_r[bram.a_addr];
      end
      if (b_acc_s) begin
        b_s1_data_r <= mem_r[bram.b_addr];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] a_s2_data_r;
      logic [DATA_WIDTH-1:0] b_s2_data_r;
      logic                  a_s2_vld_r;
      logic                  b_s2_vld_r;

      // Output register stage; data only moves with a valid result so it holds otherwise.
      always_ff @(posedge bram_clk or negedge bram_rstn) begin
        if (!bram_rstn) begin
          a_s2_data_r <= '0;
          b_s2_data_r <= '0;
          a_s2_vld_r  <= 1'b0;
          b_s2_vld_r  <= 1'b0;
        end else begin
          a_s2_vld_r <= a_s1_vld_r;
          b_s2_vld_r <= b_s1_vld_r;
          if (a_s1_vld_r) begin
            a_s2_data_r <= a_s1_data_r;
          end
          if (b_s1_vld_r) begin
            b_s2_data_r <= b_s1_data_r;
          end
        end
      end

      assign bram.a_rddata  = a_s2_data_r;
      assign bram.a_rdvalid = a_s2_vld_r;
      assign bram.b_rddata  = b_s2_data_r;
      assign bram.b_rdvalid = b_s2_vld_r;
    end else begin : g_lat1
      assign bram.a_rddata  = a_s1_data_r;
      assign bram.a_rdvalid = a_s1_vld_r;
      assign bram.b_rddata  = b_s1_data_r;
      assign bram.b_rdvalid = b_s1_vld_r;
    end
  endgenerate

  assign bram.clr_busy = clr_busy_r;
endmodule

// File: tb/tb_osnt_bram_dp.sv
// Scoreboard bench for osnt_bram_dp: identical stimulus drives a latency-1 and a latency-2
// instance; a reference memory model predicts every read result and its arrival cycle.
module tb_osnt_bram_dp;
  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic bram_clk  = 1'b0;
  logic bram_rstn = 1'b0;
  int   cyc       = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  int            clr_left = 0;
  int            clr_idx  = 0;
  exp_t          q [4][$];
  exp_t          mon_e;
  logic          mon_v [4];
  logic [DW-1:0] mon_d [4];
  string         pname [4] = '{"a_rd_lat1", "b_rd_lat1", "a_rd_lat2", "b_rd_lat2"};
  int            plat  [4] = '{1, 1, 2, 2};

  osnt_bram_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  osnt_bram_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

  osnt_bram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
    .bram_clk (bram_clk),
    .bram_rstn(bram_rstn),
    .bram     (if1)
  );

  osnt_bram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) dut2 (
    .bram_clk (bram_clk),
    .bram_rstn(bram_rstn),
    .bram     (if2)
  );

  always #5 bram_clk = ~bram_clk;

  always @(posedge bram_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rdvalid pulse must match the oldest prediction, in data and arrival cycle.
  always @(negedge bram_clk) begin
    if (bram_rstn) begin
      mon_v[0] = if1.a_rdvalid; mon_d[0] = if1.a_rddata;
      mon_v[1] = if1.b_rdvalid; mon_d[1] = if1.b_rddata;
      mon_v[2] = if2.a_rdvalid; mon_d[2] = if2.a_rddata;
      mon_v[3] = if2.b_rdvalid; mon_d[3] = if2.b_rddata;
      for (int p = 0; p < 4; p++) begin
        if (q[p].size() > 0 && q[p][0].due < cyc) begin
          mon_e = q[p].pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL %s_missing: no rdvalid by cycle %0d, required data %h at cycle %0d",
                   pname[p], cyc, mon_e.data, mon_e.due);
        end
        if (mon_v[p]) begin
          if (q[p].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_spurious: rdvalid with data %h at cycle %0d, required none",
                     pname[p], mon_d[p], cyc);
          end else begin
            mon_e = q[p].pop_front();
            chk(pname[p], mon_d[p], mon_e.data);
            chk({pname[p], "_cycle"}, DW'(cyc), DW'(mon_e.due));
          end
        end
      end
    end
  end

  task automatic drive(input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aa,
                       input logic [DW-1:0] awd, input logic be, input logic [AW-1:0] ba,
                       input logic clr);
    if1.a_en = ae; if1.a_we = awe; if1.a_addr = aa; if1.a_wrdata = awd;
    if1.b_en = be; if1.b_addr = ba; if1.clr_start = clr;
    if2.a_en = ae; if2.a_we = awe; if2.a_addr = aa; if2.a_wrdata = awd;
    if2.b_en = be; if2.b_addr = ba; if2.clr_start = clr;
  endtask

  // One clock of stimulus; the model decides what the coming edge does.
  task automatic step(input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aa,
                      input logic [DW-1:0] awd, input logic be, input logic [AW-1:0] ba,
                      input logic clr);
    exp_t e;
    @(negedge bram_clk);
    chk("clr_busy_lat1", DW'(if1.clr_busy), DW'(clr_left > 0));
    chk("clr_busy_lat2", DW'(if2.clr_busy), DW'(clr_left > 0));
    drive(ae, awe, aa, awd, be, ba, clr);
    if (clr_left > 0) begin
      ref_mem[clr_idx] = '0;
      clr_idx++;
      clr_left--;
    end else begin
      if (be) begin
        e.data = ref_mem[ba];
        for (int p = 1; p < 4; p += 2) begin
          e.due = cyc + plat[p];
          q[p].push_back(e);
        end
      end
      if (ae) begin
        e.data = ref_mem[aa];
        for (int p = 0; p < 4; p += 2) begin
          e.due = cyc + plat[p];
          q[p].push_back(e);
        end
        for (int k = 0; k < NB; k++) begin
          if (awe[k]) ref_mem[aa][8*k +: 8] = awd[8*k +: 8];
        end
      end
      if (clr) begin
        clr_left = DEPTH;
        clr_idx  = 0;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge bram_clk);
    bram_rstn = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    clr_left = 0;
    for (int p = 0; p < 4; p++) q[p].delete();
    #1;
    chk({tag, "_a_rddata1"}, if1.a_rddata, '0);
    chk({tag, "_b_rddata1"}, if1.b_rddata, '0);
    chk({tag, "_a_rddata2"}, if2.a_rddata, '0);
    chk({tag, "_b_rddata2"}, if2.b_rddata, '0);
    chk({tag, "_valid_busy"}, DW'({if1.a_rdvalid, if1.b_rdvalid, if2.a_rdvalid,
                                   if2.b_rdvalid, if1.clr_busy, if2.clr_busy}), '0);
    @(negedge bram_clk);
    @(negedge bram_clk);
    bram_rstn = 1'b1;
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, '1, AW'(i), {$urandom, $urandom} | 64'h1, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, '0, AW'(i), '0, 1'b1, AW'(DEPTH - 1 - i), 1'b0);
    end
  endtask

  initial begin
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    do_reset("init_rst");
    fill_all();

    // Write then read the same word through both ports.
    step(1'b1, '1, 4'd3, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, '0, 1'b0);
    step(1'b1, '0, 4'd3, '0, 1'b1, 4'd3, 1'b0);
    idle();

    // Byte-enable: only byte 0 changes.
    step(1'b1, '1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, 1'b0);
    step(1'b1, 8'h01, 4'd5, 64'h0, 1'b0, '0, 1'b0);
    step(1'b1, '0, 4'd5, '0, 1'b1, 4'd5, 1'b0);

    // Same-cycle collision: both ports see the old word, B sees the new one a cycle later.
    step(1'b1, '1, 4'd7, 64'h1111_2222_3333_4444, 1'b0, '0, 1'b0);
    step(1'b1, '1, 4'd7, 64'h5555_6666_7777_8888, 1'b1, 4'd7, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0);

    // Back-to-back B reads over the whole array.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0);

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), NB'($urandom), AW'($urandom), {$urandom, $urandom},
           1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 60) == 0));
    end
    while (clr_left > 0) idle();

    // Full clear with accesses attempted while busy.
    fill_all();
    step(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b1);
    for (int n = 0; n < DEPTH; n++) begin
      step(1'b1, '1, AW'($urandom), {$urandom, $urandom}, 1'b1, AW'($urandom), 1'b1);
    end
    read_all();

    // Reset with reads in flight: nothing may emerge afterwards.
    step(1'b1, '0, 4'd1, '0, 1'b1, 4'd2, 1'b0);
    do_reset("inflight_rst");
    for (int n = 0; n < 4; n++) idle();

    // Reset eight cycles into a clear: lower half zeroed, upper half intact.
    fill_all();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    for (int n = 0; n < 8; n++) idle();
    do_reset("midclr_rst");
    read_all();

    for (int n = 0; n < 4; n++) idle();
    for (int p = 0; p < 4; p++) begin
      chk({pname[p], "_pending"}, DW'(q[p].size()), '0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
